decode_stage: RTL
=================

Name: decode_stage

Overview:
- Registered, parametrised RV32I/RV64I instruction decode stage. Sits between the fetch stage and the execute stage.
- Takes a fetched instruction word plus its PC over a valid/ready handshake.
- Produces a registered decoded bundle (opcode, func3, func7, rs1, rs2, rd, sign-extended immediate, illegal flag, PC) over a valid/ready handshake.
- A one-entry skid buffer keeps full throughput under downstream backpressure. A flush input discards in-flight instructions.

Parameters:
- XLEN, 32, datapath width for the immediate and PC (32 or 64 only; any other value is a compile-time error).
- REGFILE_DEPTH, 32, number of architectural registers; register-address width is $clog2(REGFILE_DEPTH).
- INSTR_WIDTH, 32, instruction word width (fixed at 32; no compressed support).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush_in  in  1  discard all buffered and in-flight instructions
- in_valid  in  1  fetch has a valid instruction
- in_ready  out  1  stage can accept an instruction this cycle
- instr_in  in  INSTR_WIDTH  instruction word
- pc_in  in  XLEN  PC of instr_in
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts bundle
- op_code_out  out  7  instr[6:0]
- func3_out  out  3  instr[14:12] or 0
- func7_out  out  7  instr[31:25] or 0
- rs1_out / rs2_out / rd_out  out  $clog2(REGFILE_DEPTH) each  register addresses, 0 when unused
- imm_out  out  XLEN  sign-extended immediate
- pc_out  out  XLEN  registered PC
- illegal_out  out  1  unsupported opcode, or instr[1:0] != 2'b11

Behaviour:
- Reset (async assert, sync release): out_valid=0, skid valid=0, all bundle outputs=0, in_ready=1.
- Decode is combinational on instr_in and captured on accept (in_valid & in_ready). Latency is 1 cycle from accept to out_valid.
- Opcode set and field usage:
  - REG 0110011: rd, rs1, rs2, f3, f7.
  - IMM_ARITH 0010011, IMM_JUMP 1100111, IMM_LOAD 0000011: rd, rs1, f3, I-imm.
  - STORE 0100011: rs1, rs2, f3, S-imm.
  - BRANCH 1100011: rs1, rs2, f3, B-imm.
  - LUI 0110111 and AUIPC 0010111: rd, U-imm.
  - JUMP 1101111: rd, J-imm.
- Unused fields are driven to 0.
- All immediates are sign-extended from instr[31] to XLEN, per the RISC-V spec, with no func3-dependent zero-extension. For XLEN=64, U-imm bits 63:32 replicate instr[31].
- Register address fields are truncated to $clog2(REGFILE_DEPTH) bits. A field value >= REGFILE_DEPTH sets illegal_out.
- Illegal instructions are still passed downstream with illegal_out=1, all fields 0 except op_code_out and pc_out.
- Handshake: out_valid stays stable and the bundle is held constant while out_valid & !out_ready. No combinational path from out_ready to in_ready.
- Skid buffer: in_ready = !skid_valid (registered).
  - Accept while the output register is full and not draining: the word goes to skid.
  - Output drains and skid is valid: skid moves to the output, skid clears.
  - Simultaneous accept and drain with skid empty: the output register reloads directly (full throughput, 1 instruction/cycle).
- Ordering is strict FIFO; no instruction is duplicated or dropped except by flush.
- flush_in (synchronous) wins over all other events in the same cycle: out_valid=0, skid cleared, any concurrent accept discarded, in_ready=1 on the next cycle. Bundle data contents are don't-care after flush but must not toggle out_valid.
- Reset asserted mid-transfer clears all valid state immediately (async).

Optional Feature:
- Macro: DECODE_PERF_CNT_EN.
- Defined: adds outputs decoded_cnt_out and illegal_cnt_out, 32 bits each.
  - decoded_cnt_out increments on each output handshake (out_valid & out_ready).
  - illegal_cnt_out increments on each output handshake carrying illegal_out=1.
  - Both wrap at 2^32, reset to 0, and are unaffected by flush.
- Undefined: ports and logic are absent; the rest of the behaviour is identical.

Test Plan:
- XLEN=32, ADDI 0xFFF00093, out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, f3=0, imm=0xFFFFFFFF, illegal=0.
- BEQ 0xFE208EE3 -> rs1=1, rs2=2, rd=0, imm=0xFFFFFFFC. XLEN=64 run: LUI 0x123452B7 -> rd=5, imm=0x0000000012345000; LUI 0x800002B7 -> imm=0xFFFFFFFF80000000.
- Stream JAL 0x008000EF (imm=8, rd=1) then 3 further instructions with out_ready held 0 for 4 cycles -> in_ready drops after 2 accepts, bundle stable; release -> all delivered in order with no gaps or loss.
- Word 0x00000000 and opcode 1110011 -> illegal_out=1, fields 0, pc_out matches; in RV32E config (REGFILE_DEPTH=16), ADD with rd=17 -> illegal_out=1.
- Two instructions buffered (output + skid), assert flush_in together with in_valid -> next cycle out_valid=0, in_ready=1, no flushed instruction ever appears.
- With DECODE_PERF_CNT_EN: 5 handshakes including 2 illegal -> decoded_cnt_out=5, illegal_cnt_out=2; assert rst mid-stream -> counters and out_valid go to 0 immediately.

Source files
------------

// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage_if
//  Description : Handshake and bus bundle between fetch, decode and execute.
//                Input side: in_valid/in_ready, instr_in, pc_in.
//                Output side: out_valid/out_ready plus the decoded bundle
//                (op_code_out, func3_out, func7_out, rs1_out, rs2_out,
//                rd_out, imm_out, pc_out, illegal_out).
//                modport slave  : used by the decode stage itself.
//                modport master : used by the surrounding fetch/execute side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface decode_stage_if #(
    parameter int XLEN        = 32,
    parameter int RA_W        = 5,
    parameter int INSTR_WIDTH = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [INSTR_WIDTH-1:0] instr_in;
    logic [XLEN-1:0]        pc_in;

    logic                   out_valid;
    logic                   out_ready;
    logic [6:0]             op_code_out;
    logic [2:0]             func3_out;
    logic [6:0]             func7_out;
    logic [RA_W-1:0]        rs1_out;
    logic [RA_W-1:0]        rs2_out;
    logic [RA_W-1:0]        rd_out;
    logic [XLEN-1:0]        imm_out;
    logic [XLEN-1:0]        pc_out;
    logic                   illegal_out;

    modport slave (
        input  in_valid, instr_in, pc_in, out_ready,
        output in_ready, out_valid, op_code_out, func3_out, func7_out,
               rs1_out, rs2_out, rd_out, imm_out, pc_out, illegal_out
    );

    modport master (
        output in_valid, instr_in, pc_in, out_ready,
        input  in_ready, out_valid, op_code_out, func3_out, func7_out,
               rs1_out, rs2_out, rd_out, imm_out, pc_out, illegal_out
    );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : Registered RV32I/RV64I decode stage with a one-entry skid
//                buffer. Instruction words arrive over a valid/ready
//                handshake, are decoded combinationally and captured on
//                accept; the decoded bundle leaves over a second valid/ready
//                handshake one cycle later.
//  Ports       : clk      - clock, rising edge
//                rst      - asynchronous active-high reset
//                flush_in - discards every buffered and in-flight word
//                bus      - decode_stage_if.slave (both handshakes + bundle)
//                decoded_cnt_out / illegal_cnt_out - 32-bit handshake
//                counters, present only when DECODE_PERF_CNT_EN is defined
//  Macro       : DECODE_PERF_CNT_EN enables the performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter int XLEN          = 32,
    parameter int REGFILE_DEPTH = 32,
    parameter int INSTR_WIDTH   = 32
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           flush_in,
    decode_stage_if.slave       bus
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]         decoded_cnt_out,
    output logic [31:0]         illegal_cnt_out
`endif
);

    localparam int          RA_W    = (REGFILE_DEPTH > 1) ? $clog2(REGFILE_DEPTH) : 1;
    localparam logic [31:0] c_depth = 32'(REGFILE_DEPTH);

    localparam logic [6:0] c_op_reg    = 7'b0110011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;

    if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
        $error("decode_stage: XLEN must be 32 or 64");
    end
    if (INSTR_WIDTH != 32) begin : g_bad_instr_width
        $error("decode_stage: INSTR_WIDTH must be 32");
    end

    typedef struct packed {
        logic [6:0]      op;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            ill;
    } bundle_t;

    // Immediates are assembled at 32 bits, then sign-extended to XLEN.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic signed [XLEN-1:0] r;
        r = $signed(v);
        return r;
    endfunction

    logic [31:0] w_instr;
    logic        w_use_rd, w_use_rs1, w_use_rs2, w_use_f3, w_use_f7;
    logic        w_known, w_reg_bad, w_ill;
    logic [31:0] w_imm32;
    bundle_t     w_dec;

    assign w_instr = bus.instr_in;

    always_comb begin
        w_use_rd  = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_use_f3  = 1'b0;
        w_use_f7  = 1'b0;
        w_known   = 1'b1;
        w_imm32   = 32'd0;
        case (w_instr[6:0])
            c_op_reg: begin
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_use_f3  = 1'b1;
                w_use_f7  = 1'b1;
            end
            c_op_imm, c_op_jalr, c_op_load: begin
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_f3  = 1'b1;
                w_imm32   = {{20{w_instr[31]}}, w_instr[31:20]};
            end
            c_op_store: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_use_f3  = 1'b1;
                w_imm32   = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
            end
            c_op_branch: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_use_f3  = 1'b1;
                w_imm32   = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                             w_instr[30:25], w_instr[11:8], 1'b0};
            end
            c_op_lui, c_op_auipc: begin
                w_use_rd  = 1'b1;
                w_imm32   = {w_instr[31:12], 12'd0};
            end
            c_op_jal: begin
                w_use_rd  = 1'b1;
                w_imm32   = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                             w_instr[20], w_instr[30:21], 1'b0};
            end
            default: w_known = 1'b0;
        endcase
    end

    // A register index that the register file cannot hold is only an error
    // when the opcode actually uses that field.
    assign w_reg_bad = (w_use_rd  && (32'(w_instr[11:7])  >= c_depth)) ||
                       (w_use_rs1 && (32'(w_instr[19:15]) >= c_depth)) ||
                       (w_use_rs2 && (32'(w_instr[24:20]) >= c_depth));

    assign w_ill = !w_known || (w_instr[1:0] != 2'b11) || w_reg_bad;

    always_comb begin
        w_dec     = '0;
        w_dec.op  = w_instr[6:0];
        w_dec.pc  = bus.pc_in;
        w_dec.ill = w_ill;
        if (!w_ill) begin
            w_dec.f3  = w_use_f3  ? w_instr[14:12]          : 3'd0;
            w_dec.f7  = w_use_f7  ? w_instr[31:25]          : 7'd0;
            w_dec.rs1 = w_use_rs1 ? RA_W'(w_instr[19:15])   : '0;
            w_dec.rs2 = w_use_rs2 ? RA_W'(w_instr[24:20])   : '0;
            w_dec.rd  = w_use_rd  ? RA_W'(w_instr[11:7])    : '0;
            w_dec.imm = sext32(w_imm32);
        end
    end

    // Output register plus one skid entry: behaves as a two-deep FIFO whose
    // ready depends only on skid occupancy, so out_ready never reaches
    // in_ready combinationally.
    bundle_t r_out;
    bundle_t r_skid;
    logic    r_out_valid;
    logic    r_skid_valid;
    logic    w_accept;
    logic    w_drain;

    assign bus.in_ready = !r_skid_valid;
    assign w_accept     = bus.in_valid && !r_skid_valid;
    assign w_drain      = r_out_valid && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out        <= '0;
            r_skid       <= '0;
        end else if (flush_in) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_out_valid || w_drain) begin
            // Output slot frees this cycle; the older skid entry goes first.
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out        <= w_dec;
                r_out_valid  <= 1'b1;
            end else begin
                r_out_valid  <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end

    assign bus.out_valid   = r_out_valid;
    assign bus.op_code_out = r_out.op;
    assign bus.func3_out   = r_out.f3;
    assign bus.func7_out   = r_out.f7;
    assign bus.rs1_out     = r_out.rs1;
    assign bus.rs2_out     = r_out.rs2;
    assign bus.rd_out      = r_out.rd;
    assign bus.imm_out     = r_out.imm;
    assign bus.pc_out      = r_out.pc;
    assign bus.illegal_out = r_out.ill;

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] r_decoded_cnt;
    logic [31:0] r_illegal_cnt;

    // Counters follow the output handshake only; flush does not touch them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_decoded_cnt <= 32'd0;
            r_illegal_cnt <= 32'd0;
        end else if (w_drain) begin
            r_decoded_cnt <= r_decoded_cnt + 32'd1;
            if (r_out.ill) begin
                r_illegal_cnt <= r_illegal_cnt + 32'd1;
            end
        end
    end

    assign decoded_cnt_out = r_decoded_cnt;
    assign illegal_cnt_out = r_illegal_cnt;
`endif

endmodule
`default_nettype wire
